// File: rtl/data_mem_pkg.sv
// Shared types and constants for the sequential data memory and its reset-time fill sequencer.
package data_mem_pkg;

  typedef enum logic {
    StInit,
    StIdle
  } state_e;

  localparam int unsigned INIT_ZERO  = 0;
  localparam int unsigned INIT_IDENT = 1;

endpackage

// File: rtl/data_mem.sv
// The storage top is defined in data_mem_seq.sv; no module is declared here.

// File: rtl/mem_init_seq.sv
// Fill counter and INIT->IDLE handoff: walks every address once after reset, then reports done.
module mem_init_seq
  import data_mem_pkg::*;
#(
  parameter int unsigned A = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic [A-1:0] fill_addr_o,
  output logic         fill_we_o,
  output logic         done_o
);

  localparam logic [A-1:0] LastAddr = {A{1'b1}};

  state_e       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + A'(1);
        // The edge that writes the last entry is also the handoff edge.
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      StIdle: begin
        cnt_d = cnt_q;
      end
      default: state_d = StInit;
    endcase
  end

  assign fill_addr_o = cnt_q;
  assign fill_we_o   = (state_q == StInit) && !rst_i;
  assign done_o      = (state_q == StIdle);

endmodule

// File: rtl/data_mem_seq.sv
// Sequential data memory: reset-time fill, then one base+offset load or store per cycle.
module data_mem_seq
  import data_mem_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned A         = 8,
  parameter int unsigned INIT_MODE = INIT_IDENT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req,
  input  logic         WriteEn,
  input  logic [A-1:0] DataAddress,
  input  logic [A-1:0] Offset,
  input  logic [W-1:0] DataIn,
  output logic         Ready,
  output logic [W-1:0] DataOut,
  output logic         DataValid
);

  logic [W-1:0] mem_q [2**A];

  logic [A-1:0] fill_addr;
  logic         fill_we;
  logic         done;

  mem_init_seq #(
    .A (A)
  ) u_init (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .fill_addr_o (fill_addr),
    .fill_we_o   (fill_we),
    .done_o      (done)
  );

  assign Ready = done;

  logic [A-1:0] eff_addr;
  logic         accept, do_store, do_load;
  logic         mem_we;
  logic [A-1:0] mem_waddr;
  logic [W-1:0] mem_wdata, fill_data;

  // Carry out of the address sum is dropped so accesses wrap around the array.
  assign eff_addr = DataAddress + Offset;
  assign accept   = Req && done && !Reset;
  assign do_store = accept && WriteEn;
  assign do_load  = accept && !WriteEn;

  assign fill_data = (INIT_MODE == INIT_IDENT) ? W'(fill_addr) : '0;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = fill_addr;
    mem_wdata = fill_data;
    if (fill_we) begin
      mem_we = 1'b1;
    end else if (do_store) begin
      mem_we    = 1'b1;
      mem_waddr = eff_addr;
      mem_wdata = DataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  logic [W-1:0] data_out_q, data_out_d;
  logic         data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = do_load;
    if (do_load) data_out_d = mem_q[eff_addr];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign DataOut   = data_out_q;
  assign DataValid = data_valid_q;

endmodule

// File: tb/tb_data_mem_seq.sv
// Directed bench: 8x256 identity-filled instance and a 16x16 zero-filled instance.
module tb_data_mem_seq;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: W=8, A=8, INIT_IDENT
  logic       rst_a = 1'b1, req_a = 1'b0, we_a = 1'b0;
  logic [7:0] addr_a = '0, off_a = '0, din_a = '0;
  logic       rdy_a, vld_a;
  logic [7:0] dout_a;

  data_mem_seq #(.W(8), .A(8), .INIT_MODE(INIT_IDENT)) u_dut_a (
    .Clk         (clk),
    .Reset       (rst_a),
    .Req         (req_a),
    .WriteEn     (we_a),
    .DataAddress (addr_a),
    .Offset      (off_a),
    .DataIn      (din_a),
    .Ready       (rdy_a),
    .DataOut     (dout_a),
    .DataValid   (vld_a)
  );

  // Instance B: W=16, A=4, INIT_ZERO
  logic        rst_b = 1'b1, req_b = 1'b0, we_b = 1'b0;
  logic [3:0]  addr_b = '0, off_b = '0;
  logic [15:0] din_b = '0;
  logic        rdy_b, vld_b;
  logic [15:0] dout_b;

  data_mem_seq #(.W(16), .A(4), .INIT_MODE(INIT_ZERO)) u_dut_b (
    .Clk         (clk),
    .Reset       (rst_b),
    .Req         (req_b),
    .WriteEn     (we_b),
    .DataAddress (addr_b),
    .Offset      (off_b),
    .DataIn      (din_b),
    .Ready       (rdy_b),
    .DataOut     (dout_b),
    .DataValid   (vld_b)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Two reset edges, then fill; a store attempted during fill must be ignored.
    tick(2);
    check("a_rst_ready", 32'(rdy_a), 32'h0);
    check("a_rst_dout", 32'(dout_a), 32'h0);
    check("a_rst_valid", 32'(vld_a), 32'h0);
    rst_a = 1'b0;
    req_a = 1'b1; we_a = 1'b1; din_a = 8'hFF; addr_a = 8'h00; off_a = 8'h00;
    tick(255);
    check("a_ready_low_255", 32'(rdy_a), 32'h0);
    req_a = 1'b0; we_a = 1'b0;
    tick(1);
    check("a_ready_at_256", 32'(rdy_a), 32'h1);
    check("a_valid_idle", 32'(vld_a), 32'h0);

    // Load 0x37 + 0
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h37; off_a = 8'h00;
    tick(1);
    req_a = 1'b0;
    check("a_load37_valid", 32'(vld_a), 32'h1);
    check("a_load37_data", 32'(dout_a), 32'h37);
    tick(1);
    check("a_hold_valid", 32'(vld_a), 32'h0);
    check("a_hold_data", 32'(dout_a), 32'h37);

    // Store during fill at address 0 must not have landed
    req_a = 1'b1; addr_a = 8'h00;
    tick(1);
    check("a_load00_data", 32'(dout_a), 32'h00);
    check("a_load00_valid", 32'(vld_a), 32'h1);

    // Wrap-around store 0xF0+0x20 -> 0x10, then load 0x10
    we_a = 1'b1; din_a = 8'hA5; addr_a = 8'hF0; off_a = 8'h20;
    tick(1);
    check("a_store_valid", 32'(vld_a), 32'h0);
    we_a = 1'b0; addr_a = 8'h10; off_a = 8'h00;
    tick(1);
    check("a_wrap_data", 32'(dout_a), 32'hA5);
    check("a_wrap_valid", 32'(vld_a), 32'h1);

    // Back-to-back store then load at 0x03
    we_a = 1'b1; din_a = 8'h5A; addr_a = 8'h03;
    tick(1);
    we_a = 1'b0;
    tick(1);
    req_a = 1'b0;
    check("a_b2b_data", 32'(dout_a), 32'h5A);
    check("a_b2b_valid", 32'(vld_a), 32'h1);
    tick(1);
    check("a_b2b_pulse", 32'(vld_a), 32'h0);

    // Load with offset wrap: 0xFF + 0x02 -> 0x01 (identity)
    req_a = 1'b1; addr_a = 8'hFF; off_a = 8'h02;
    tick(1);
    req_a = 1'b0;
    check("a_off_wrap", 32'(dout_a), 32'h01);

    // Reset, then reset again mid-fill at counter 100 with a load pending
    rst_a = 1'b1;
    tick(1);
    check("a_rst2_dout", 32'(dout_a), 32'h0);
    rst_a = 1'b0;
    tick(100);
    check("a_midfill_ready", 32'(rdy_a), 32'h0);
    rst_a = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 8'h03; off_a = 8'h00;
    tick(1);
    check("a_midrst_ready", 32'(rdy_a), 32'h0);
    check("a_midrst_valid", 32'(vld_a), 32'h0);
    check("a_midrst_dout", 32'(dout_a), 32'h0);
    rst_a = 1'b0; req_a = 1'b0;
    tick(255);
    check("a_refill_low_255", 32'(rdy_a), 32'h0);
    tick(1);
    check("a_refill_ready", 32'(rdy_a), 32'h1);
    req_a = 1'b1; addr_a = 8'h03;
    tick(1);
    req_a = 1'b0;
    check("a_refill_03", 32'(dout_a), 32'h03);

    // Instance B: zero fill, 16-cycle init
    rst_b = 1'b0;
    tick(15);
    check("b_ready_low_15", 32'(rdy_b), 32'h0);
    tick(1);
    check("b_ready_at_16", 32'(rdy_b), 32'h1);
    for (int i = 0; i < 16; i++) begin
      req_b = 1'b1; we_b = 1'b0; addr_b = 4'(i); off_b = 4'h0;
      tick(1);
      check($sformatf("b_load_%0d_data", i), 32'(dout_b), 32'h0);
      check($sformatf("b_load_%0d_valid", i), 32'(vld_b), 32'h1);
    end
    req_b = 1'b0;
    tick(1);
    check("b_idle1_valid", 32'(vld_b), 32'h0);
    tick(1);
    check("b_idle2_valid", 32'(vld_b), 32'h0);
    // 0xE + 0x5 wraps to 0x3 in a 16-entry array
    req_b = 1'b1; we_b = 1'b1; din_b = 16'hBEEF; addr_b = 4'hE; off_b = 4'h5;
    tick(1);
    we_b = 1'b0; addr_b = 4'h3; off_b = 4'h0;
    tick(1);
    req_b = 1'b0;
    check("b_wrap_data", 32'(dout_b), 32'hBEEF);
    check("b_wrap_valid", 32'(vld_b), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_seq.md
DATA_MEM_SEQ -- requirements
Module: data_mem_seq

Interface
REQ-001 SHALL have parameter W, default 8, data word width in bits.
REQ-002 SHALL have parameter A, default 8, address width; depth 2**A words.
REQ-003 SHALL have parameter INIT_MODE, default INIT_IDENT, reset-time fill pattern (INIT_ZERO or INIT_IDENT).
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port Req  input  1  access request, qualified by Ready.
REQ-007 SHALL have port WriteEn  input  1  with Req: 1 = store, 0 = load.
REQ-008 SHALL have port DataAddress  input  A  base pointer.
REQ-009 SHALL have port Offset  input  A  offset added to base.
REQ-010 SHALL have port DataIn  input  W  store data.
REQ-011 SHALL have port Ready  output  1  high when the block accepts a request.
REQ-012 SHALL have port DataOut  output  W  registered load data.
REQ-013 SHALL have port DataValid  output  1  one-cycle pulse marking new DataOut.

Function
REQ-014 SHALL implement a two-state FSM: INIT and IDLE.
REQ-015 SHALL, in INIT, write one entry per cycle from address 0 upward using an A-bit fill counter: INIT_ZERO writes 0; INIT_IDENT writes the index truncated/zero-extended to W.
REQ-016 SHALL transition INIT -> IDLE on the edge that writes entry 2**A-1; Ready SHALL be 1 from that edge onward, exactly 2**A cycles after the last Reset-high edge.
REQ-017 SHALL hold Ready at 0 throughout INIT and ignore Req, WriteEn, DataIn and addresses there.
REQ-018 SHALL accept a request on any edge where Req=1 and Ready=1; Ready SHALL stay 1 in IDLE, giving one access per cycle back-to-back.
REQ-019 SHALL form the effective address as (DataAddress + Offset) mod 2**A, discarding the carry, e.g. 8'hF0 + 8'h20 -> 8'h10.
REQ-020 SHALL, on an accepted store, write DataIn to the effective address at that edge; DataValid SHALL be 0 the following cycle.
REQ-021 SHALL, on an accepted load, register the word at the effective address into DataOut and assert DataValid for exactly the next cycle (latency 1).
REQ-022 SHALL hold DataOut unchanged until the next accepted load; DataValid SHALL be 0 in every cycle not following an accepted load.
REQ-023 SHALL return the newly stored value to a load issued in the cycle after a store to the same address.
REQ-024 SHALL neither read nor write memory when Req=0 in IDLE.

Reset
REQ-025 SHALL, on any edge with Reset=1, enter INIT, clear the fill counter, set Ready=0, DataValid=0 and DataOut=0.
REQ-026 SHALL, if Reset is asserted during INIT or IDLE, restart the fill from address 0 and discard any access in that cycle.
REQ-027 SHALL not write memory in any cycle where Reset=1; the fill starts on the first edge with Reset=0.

Structure
REQ-028 SHALL place the FSM state enum and the INIT_ZERO/INIT_IDENT constants in shared package data_mem_pkg.
REQ-029 SHALL hold storage as a 2**A x W register array inside data_mem_seq, with a single write port muxed between fill and store.
REQ-030 SHALL isolate the fill counter and INIT->IDLE handoff in sub-module mem_init_seq (outputs: fill address, fill write enable, done).

Verification
REQ-031 SHALL cover: W=8, A=8, INIT_IDENT, Reset 2 cycles then low -> Ready rises 256 cycles later; load 8'h37 + 0 -> DataOut=8'h37 with DataValid 1 cycle later.
REQ-032 SHALL cover: store 8'hA5 at base 8'hF0 offset 8'h20, then load base 8'h10 offset 0 -> DataOut=8'hA5 (wrap-around).
REQ-033 SHALL cover: back-to-back store 8'h5A at 8'h03 then load 8'h03 next cycle -> DataOut=8'h5A, DataValid high exactly one cycle.
REQ-034 SHALL cover: Req with WriteEn=1, DataIn=8'hFF at address 8'h00 during INIT -> ignored; after Ready, load 8'h00 -> 8'h00.
REQ-035 SHALL cover: Reset asserted mid-fill at counter 100 -> Ready stays 0 and rises 256 cycles after Reset deasserts; DataOut=0, DataValid=0 during reset.
REQ-036 SHALL cover: W=16, A=4, INIT_ZERO -> Ready after 16 cycles; load of all 16 addresses returns 16'h0000; Req=0 idle cycles keep DataValid=0.
